mul4_seq_ctrl: RTL

Sequencer that computes a 4-bit x 4-bit = 8-bit unsigned product using one shared 2-bit x 2-bit combinational multiplier core over four clock cycles. The block latches operands on a start handshake and drives the core's operand inputs one 2-bit slice pair per cycle. It shifts and accumulates the core's 4-bit partial products and signals completion with a one-cycle done pulse. The 2x2 core sits outside this block and connects through the mul_* ports, so it can later be shared or swapped.

---
 rtl/mul_seq_pkg.sv | 8 +
 rtl/mul4_seq_slice_mux.sv | 19 +
 rtl/mul4_seq_ctrl.sv | 67 ++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the 4x4 sequential multiplier built on a 2x2 core.
package mul_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int OP_W = 4;
   localparam int SLICE_W = 2;
   localparam int PROD_W = 8;
   localparam logic [2:0] SHIFT_STEP [4] = '{3'd0, 3'd2, 3'd2, 3'd4};
endpackage

// File: rtl/mul4_seq_slice_mux.sv
// mul4_seq_slice_mux: picks the operand slice pair and partial-product shift for each step.
module mul4_seq_slice_mux
   import mul_seq_pkg::*;
(
   input  logic               run,
   input  logic [1:0]         step,
   input  logic [OP_W-1:0]    a,
   input  logic [OP_W-1:0]    b,
   output logic [SLICE_W-1:0] mul_a,
   output logic [SLICE_W-1:0] mul_b,
   output logic [2:0]         shift
);
   // step bit 0 selects the high slice of a, step bit 1 the high slice of b
   always_comb begin
      mul_a = run ? (step[0] ? a[3:2] : a[1:0]) : '0;
      mul_b = run ? (step[1] ? b[3:2] : b[1:0]) : '0;
      shift = SHIFT_STEP[step];
   end
endmodule

// File: rtl/mul4_seq_ctrl.sv
// mul4_seq_ctrl: 4x4 unsigned multiply over four cycles using an external 2x2 core.
module mul4_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter bit HOLD_RESULT = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [OP_W-1:0]    a,
   input  logic [OP_W-1:0]    b,
   output logic               ready,
   output logic               done,
   output logic [PROD_W-1:0]  prod,
   output logic [SLICE_W-1:0] mul_a,
   output logic [SLICE_W-1:0] mul_b,
   input  logic [3:0]         mul_p
);
   state_t state, state_nx;
   logic [1:0] step;
   logic [OP_W-1:0] a_q, b_q;
   logic [PROD_W-1:0] acc, prod_q, sum;
   logic [2:0] shift;
   logic accept;

   mul4_seq_slice_mux u_mux (
      .run   (state == RUN),
      .step  (step),
      .a     (a_q),
      .b     (b_q),
      .mul_a (mul_a),
      .mul_b (mul_b),
      .shift (shift)
   );

   always_comb begin
      accept = start && (state != RUN);
      state_nx = accept ? RUN : (state == RUN) ? ((step == 2'd3) ? DONE : RUN) : IDLE;
      ready = state != RUN;
      done = state == DONE;
      sum = acc + (PROD_W'(mul_p) << shift);
      prod = (HOLD_RESULT || done) ? prod_q : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         step <= '0;
         acc <= '0;
         prod_q <= '0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            step <= '0;
         end else if (state == RUN) begin
            acc <= sum;
            step <= step + 2'd1;
            if (step == 2'd3) prod_q <= sum;
         end
      end
   end
endmodule
